i2c_byte_sequencer: RTL and testbench
=====================================

// Module: i2c_byte_sequencer
// PURPOSE
//  Sequences one I2C byte transfer (DATA_BITS data bits + ACK slot) for the I2C master FSM.
//  Drives the team's 4-bit bit counter through its rst_count_2/count_inc controls.
//  Shifts tx data onto SDA, or shifts SDA into rx_byte, and handles the ACK bit.
//  Sits between the master command FSM (start/done handshake) and the SCL generator (phase ticks).
// PARAMETERS
//  DATA_BITS  8  data bits per transfer, legal 1..15 (bounded by the 4-bit counter), MSB first
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          asynchronous reset, active-low
//  start      in   1          1-cycle request; accepted only in IDLE
//  rw         in   1          0 = write (master drives data), 1 = read (slave drives data)
//  tx_byte    in   DATA_BITS  write data, captured at accept
//  send_ack   in   1          read only: 1 = master ACKs (SDA low), 0 = NACK; captured at accept
//  abort      in   1          synchronous abort, any state
//  scl_rise   in   1          1-cycle tick, SCL low->high (sample point)
//  scl_fall   in   1          1-cycle tick, SCL high->low (change point)
//  sda_in     in   1          synchronised SDA line
//  sda_oe     out  1          1 = pull SDA low (open drain), 0 = release
//  busy       out  1          high from accept until done/abort
//  done       out  1          1-cycle pulse at transfer end
//  rx_byte    out  DATA_BITS  read data; updated only at done of a read
//  ack_rcvd   out  1          write only: sda_in sampled in ACK slot (0 = slave ACKed)
// BEHAVIOUR
//  Reset: state IDLE, sda_oe=0, busy=0, done=0, rx_byte=0, ack_rcvd=1, shift reg=0, bit counter=0.
//  States: IDLE -> DATA -> ACK -> IDLE (done pulse on the ACK->IDLE transition).
//  Caller issues start only while SCL is low; the START condition is produced elsewhere.
//  IDLE: start=1 -> capture rw/tx_byte/send_ack; assert rst_count_2; busy=1 next cycle; -> DATA.
//    Write: sda_oe=~tx_byte[MSB] from the first DATA cycle.
//  DATA, on scl_rise: count_inc=1. Read: shift sda_in into shift reg LSB.
//  DATA, on scl_fall with count<DATA_BITS: write -> shift left, sda_oe=~next bit.
//  DATA, on scl_fall with count==DATA_BITS: -> ACK.
//    Write: sda_oe=0 (release for slave ACK).
//    Read: sda_oe=send_ack.
//  ACK, on scl_rise: write -> ack_rcvd<=sda_in; read -> rx_byte<=shift reg.
//  ACK, on scl_fall: sda_oe=0; rst_count_2=1; done=1 for one cycle; busy=0; -> IDLE.
//  Latency: done is the clk cycle after the (DATA_BITS+1)th scl_fall following accept.
//  Counter: count_inc only on scl_rise in DATA. rst_count_2 on accept, ACK exit and abort.
//  rst_count_2 has priority over count_inc. count never exceeds DATA_BITS; no wrap.
//  start while busy: ignored, no effect on the transfer in progress.
//  scl_rise and scl_fall in the same cycle: protocol error; scl_rise acted on, scl_fall dropped.
//  abort: -> IDLE next cycle; sda_oe=0, busy=0, no done; rx_byte/ack_rcvd unchanged; counter cleared.
//  abort has priority over start and ticks in the same cycle.
//  rst_n low mid-transfer: immediate return to reset values; SDA released asynchronously.
//  Ticks in IDLE: ignored.
// STRUCTURE
//  Shared package/include i2c_defs: state encodings (ST_IDLE, ST_DATA, ST_ACK), RW_WRITE/RW_READ,
//    ACK=0 / NACK=1 line-level constants.
//  Sub-module: existing 4-bit `counter` (rst_count_2, count_inc, count) instantiated as u_bit_cnt.
//  FSM, shift register and output registers are local. All outputs are registered.
// TESTING
//  1 Write 0xA5, slave ACKs (sda_in=0 in ACK slot):
//    sda_oe over 8 bits = 0,1,0,1,1,0,1,0; ack_rcvd=0; one done pulse; busy low after.
//  2 Read, sda_in pattern 0x3C, send_ack=1:
//    rx_byte=0x3C at done; sda_oe=1 only in ACK slot.
//  3 Read 0xFF with send_ack=0 (NACK):
//    sda_oe stays 0 throughout; rx_byte=0xFF; done asserted.
//  4 Write, slave NACKs (sda_in=1):
//    ack_rcvd=1. Then start pulsed mid-transfer: ignored, bit count unchanged.
//  5 abort after 3 scl_rise:
//    next cycle IDLE, sda_oe=0, busy=0, no done, count=0.
//    A new write of 0x01 then completes correctly.
//  6 rst_n asserted mid-read:
//    all outputs at reset values immediately.
//    DATA_BITS=4 run: done after 5th scl_fall, rx_byte 4 bits wide.

Source files
------------

// File: rtl/i2c_defs.sv
// Shared I2C encodings: sequencer states, transfer direction and ACK line levels.
package i2c_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/counter.sv
// Bit counter: synchronous clear with priority over increment, saturates at all-ones.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst_count_2,
    input  logic             count_inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (rst_count_2) begin
            count_q <= '0;
        end else if (count_inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Sequences one I2C byte (DATA_BITS data bits MSB first, then the ACK slot) on SCL phase ticks.
module i2c_byte_sequencer
    import i2c_defs::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] tx_byte,
    input  logic                 send_ack,
    input  logic                 abort,
    input  logic                 scl_rise,
    input  logic                 scl_fall,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 ack_rcvd
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS);

    state_e               state_q, state_d;
    logic                 rw_q, rw_d;
    logic                 send_ack_q, send_ack_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 ack_rcvd_q, ack_rcvd_d;

    logic [DATA_BITS-1:0] shifted;
    logic                 rst_count_2;
    logic                 count_inc;
    logic [CNT_W-1:0]     bit_count;

    counter #(
        .WIDTH(CNT_W)
    ) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_count_2(rst_count_2),
        .count_inc  (count_inc),
        .count      (bit_count)
    );

    assign shifted = shift_q << 1;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        send_ack_d  = send_ack_q;
        shift_d     = shift_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rx_byte_d   = rx_byte_q;
        ack_rcvd_d  = ack_rcvd_q;
        rst_count_2 = 1'b0;
        count_inc   = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            rst_count_2 = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_DATA;
                        rw_d        = rw;
                        send_ack_d  = send_ack;
                        shift_d     = tx_byte;
                        sda_oe_d    = (rw == RW_WRITE) ? ~tx_byte[DATA_BITS-1] : 1'b0;
                        busy_d      = 1'b1;
                        rst_count_2 = 1'b1;
                    end
                end
                ST_DATA: begin
                    // A rise coinciding with a fall is a protocol error; the fall is dropped.
                    if (scl_rise) begin
                        count_inc = (bit_count < LAST_BIT);
                        if (rw_q == RW_READ) begin
                            shift_d = shifted | DATA_BITS'(sda_in);
                        end
                    end else if (scl_fall) begin
                        if (bit_count < LAST_BIT) begin
                            if (rw_q == RW_WRITE) begin
                                shift_d  = shifted;
                                sda_oe_d = ~shifted[DATA_BITS-1];
                            end
                        end else begin
                            state_d  = ST_ACK;
                            sda_oe_d = (rw_q == RW_WRITE) ? 1'b0 : send_ack_q;
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_rise) begin
                        if (rw_q == RW_WRITE) begin
                            ack_rcvd_d = sda_in;
                        end else begin
                            rx_byte_d = shift_q;
                        end
                    end else if (scl_fall) begin
                        state_d     = ST_IDLE;
                        sda_oe_d    = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        rst_count_2 = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: all state is in the async reset, so SDA is released the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rw_q       <= RW_WRITE;
            send_ack_q <= 1'b0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_byte_q  <= '0;
            ack_rcvd_q <= NACK;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            send_ack_q <= send_ack_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_byte_q  <= rx_byte_d;
            ack_rcvd_q <= ack_rcvd_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_byte  = rx_byte_q;
    assign ack_rcvd = ack_rcvd_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Directed bench for i2c_byte_sequencer: 8-bit instance plus a DATA_BITS=4 instance.
module tb_i2c_byte_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic       rw;
    logic [7:0] tx_byte;
    logic [3:0] tx_byte4;
    logic       send_ack;
    logic       abort;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_in;
    logic       sda_oe, sda_oe4;
    logic       busy, busy4;
    logic       done, done4;
    logic [7:0] rx_byte;
    logic [3:0] rx_byte4;
    logic       ack_rcvd, ack_rcvd4;

    int checks = 0;
    int errors = 0;

    i2c_byte_sequencer #(.DATA_BITS(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rw      (rw),
        .tx_byte (tx_byte),
        .send_ack(send_ack),
        .abort   (abort),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte),
        .ack_rcvd(ack_rcvd)
    );

    i2c_byte_sequencer #(.DATA_BITS(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .rw      (rw),
        .tx_byte (tx_byte4),
        .send_ack(send_ack),
        .abort   (abort),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe4),
        .busy    (busy4),
        .done    (done4),
        .rx_byte (rx_byte4),
        .ack_rcvd(ack_rcvd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rise();
        scl_rise = 1'b1;
        step(1);
        scl_rise = 1'b0;
    endtask

    task automatic pulse_fall();
        scl_fall = 1'b1;
        step(1);
        scl_fall = 1'b0;
    endtask

    // One SCL period: present sda, rise, sample sda_oe while SCL is high, fall.
    task automatic bit_cycle(input logic sda_val, output logic oe_obs);
        sda_in = sda_val;
        pulse_rise();
        step(1);
        oe_obs = sda_oe;
        pulse_fall();
        step(1);
    endtask

    task automatic run_byte(input logic [7:0] sda_pat, output logic [7:0] oe_vec);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(sda_pat[i], o);
            oe_vec[i] = o;
        end
    endtask

    task automatic begin_xfer(input logic rw_v, input logic [7:0] tx_v, input logic ack_v);
        rw       = rw_v;
        tx_byte  = tx_v;
        send_ack = ack_v;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
    endtask

    initial begin
        logic [7:0] oe_vec;
        logic       o;

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; rw = 1'b0; tx_byte = 8'h00;
        tx_byte4 = 4'h0; send_ack = 1'b0; abort = 1'b0; scl_rise = 1'b0;
        scl_fall = 1'b0; sda_in = 1'b1;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        check("reset_sda_oe", 16'(sda_oe), 16'h0);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        check("reset_rx_byte", 16'(rx_byte), 16'h00);
        check("reset_ack_rcvd", 16'(ack_rcvd), 16'h1);

        // 1: write 0xA5, slave ACKs
        begin_xfer(1'b0, 8'hA5, 1'b0);
        check("w1_busy", 16'(busy), 16'h1);
        check("w1_first_oe", 16'(sda_oe), 16'h0);
        check("w1_count_start", 16'(dut.bit_count), 16'h0);
        run_byte(8'hFF, oe_vec);
        check("w1_oe_bits", 16'(oe_vec), 16'h5A);
        check("w1_count_full", 16'(dut.bit_count), 16'h8);
        sda_in = 1'b0;
        pulse_rise();
        step(1);
        check("w1_ack_released", 16'(sda_oe), 16'h0);
        check("w1_done_early", 16'(done), 16'h0);
        pulse_fall();
        check("w1_done", 16'(done), 16'h1);
        check("w1_busy_after", 16'(busy), 16'h0);
        check("w1_ack_rcvd", 16'(ack_rcvd), 16'h0);
        step(1);
        check("w1_done_pulse", 16'(done), 16'h0);

        // 2: read 0x3C, master ACKs
        begin_xfer(1'b1, 8'h00, 1'b1);
        run_byte(8'h3C, oe_vec);
        check("r2_oe_data", 16'(oe_vec), 16'h00);
        check("r2_oe_ack", 16'(sda_oe), 16'h1);
        check("r2_rx_hold", 16'(rx_byte), 16'h00);
        pulse_rise();
        step(1);
        pulse_fall();
        check("r2_done", 16'(done), 16'h1);
        check("r2_rx_byte", 16'(rx_byte), 16'h3C);
        check("r2_oe_after", 16'(sda_oe), 16'h0);

        // 3: read 0xFF, master NACKs
        begin_xfer(1'b1, 8'h00, 1'b0);
        run_byte(8'hFF, oe_vec);
        check("r3_oe_data", 16'(oe_vec), 16'h00);
        check("r3_oe_ack", 16'(sda_oe), 16'h0);
        pulse_rise();
        step(1);
        pulse_fall();
        check("r3_done", 16'(done), 16'h1);
        check("r3_rx_byte", 16'(rx_byte), 16'hFF);

        // 4: write 0x5A, start pulsed mid-transfer, slave NACKs
        begin_xfer(1'b0, 8'h5A, 1'b0);
        for (int i = 7; i >= 5; i--) begin
            bit_cycle(1'b1, o);
            oe_vec[i] = o;
        end
        check("w4_count_mid", 16'(dut.bit_count), 16'h3);
        begin_xfer(1'b1, 8'h00, 1'b1);
        check("w4_count_after_start", 16'(dut.bit_count), 16'h3);
        check("w4_busy_after_start", 16'(busy), 16'h1);
        for (int i = 4; i >= 0; i--) begin
            bit_cycle(1'b1, o);
            oe_vec[i] = o;
        end
        check("w4_oe_bits", 16'(oe_vec), 16'hA5);
        sda_in = 1'b1;
        pulse_rise();
        step(1);
        pulse_fall();
        check("w4_done", 16'(done), 16'h1);
        check("w4_ack_rcvd", 16'(ack_rcvd), 16'h1);
        check("w4_rx_untouched", 16'(rx_byte), 16'hFF);

        // 5: abort after 3 rises, then a clean write of 0x01
        begin_xfer(1'b0, 8'h00, 1'b0);
        bit_cycle(1'b1, o);
        bit_cycle(1'b1, o);
        pulse_rise();
        check("a5_count_3", 16'(dut.bit_count), 16'h3);
        check("a5_oe_driven", 16'(sda_oe), 16'h1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("a5_busy", 16'(busy), 16'h0);
        check("a5_oe", 16'(sda_oe), 16'h0);
        check("a5_done", 16'(done), 16'h0);
        check("a5_count", 16'(dut.bit_count), 16'h0);
        check("a5_ack_kept", 16'(ack_rcvd), 16'h1);
        check("a5_rx_kept", 16'(rx_byte), 16'hFF);
        pulse_fall();
        check("a5_idle_tick_done", 16'(done), 16'h0);
        check("a5_idle_tick_busy", 16'(busy), 16'h0);
        begin_xfer(1'b0, 8'h01, 1'b0);
        run_byte(8'hFF, oe_vec);
        check("a5_w_oe_bits", 16'(oe_vec), 16'hFE);
        sda_in = 1'b0;
        pulse_rise();
        step(1);
        pulse_fall();
        check("a5_w_done", 16'(done), 16'h1);
        check("a5_w_ack", 16'(ack_rcvd), 16'h0);

        // 6: reset while the master drives ACK of a read
        begin_xfer(1'b1, 8'h00, 1'b1);
        run_byte(8'h81, oe_vec);
        check("r6_oe_ack", 16'(sda_oe), 16'h1);
        rst_n = 1'b0;
        #1;
        check("r6_rst_oe", 16'(sda_oe), 16'h0);
        check("r6_rst_busy", 16'(busy), 16'h0);
        check("r6_rst_done", 16'(done), 16'h0);
        check("r6_rst_rx", 16'(rx_byte), 16'h00);
        check("r6_rst_ack", 16'(ack_rcvd), 16'h1);
        check("r6_rst_count", 16'(dut.bit_count), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // DATA_BITS=4 read of 0xB, master NACKs
        rw = 1'b1;
        send_ack = 1'b0;
        start4 = 1'b1;
        step(1);
        start4 = 1'b0;
        check("d4_busy", 16'(busy4), 16'h1);
        bit_cycle(1'b1, o);
        bit_cycle(1'b0, o);
        bit_cycle(1'b1, o);
        bit_cycle(1'b1, o);
        check("d4_no_done_4th_fall", 16'(done4), 16'h0);
        pulse_rise();
        step(1);
        pulse_fall();
        check("d4_done_5th_fall", 16'(done4), 16'h1);
        check("d4_rx_byte", 16'(rx_byte4), 16'hB);
        check("d4_busy_after", 16'(busy4), 16'h0);
        check("d4_main_idle", 16'(busy), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
